// File: rtl/entry_allocator.sv
// Free-bitmap entry allocator: offers one free & eligible entry per cycle
// (fixed low/high priority or round-robin), accepts one release per cycle, and flushes.

module entry_slot (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic set,
  input  logic clr,
  output logic free
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     free <= 1'b1;
    else if (flush) free <= 1'b1;
    else if (clr)   free <= 1'b0;
    else if (set)   free <= 1'b1;
  end
endmodule

module entry_allocator #(
  parameter int DEPTH         = 64,
  parameter int IDX_W         = $clog2(DEPTH),
  parameter bit HIGH_PRIORITY = 1'b0,
  parameter bit ROUND_ROBIN   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DEPTH-1:0] eligible,
  input  logic             alloc_ready,
  output logic             alloc_valid,
  output logic [IDX_W-1:0] alloc_idx,
  input  logic             free_valid,
  input  logic [IDX_W-1:0] free_idx,
  input  logic             flush,
  output logic [IDX_W:0]   free_count,
  output logic             full,
  output logic             empty,
  output logic             err_dbl_free
);
  localparam logic [IDX_W:0] DEPTH_CNT = (IDX_W+1)'(DEPTH);

  logic [DEPTH-1:0] free_bits;
  logic [DEPTH-1:0] cand;
  logic [DEPTH-1:0] rot;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] rr_off;
  logic             grant;
  logic             rel_ok;
  logic             rel_dbl;

  assign cand = free_bits & eligible;
  // Rotating the doubled vector puts rr_ptr at bit 0, so a plain low-first scan wraps.
  assign rot  = DEPTH'({cand, cand} >> rr_ptr);

  always_comb begin
    sel_idx = '0;
    rr_off  = '0;
    if (ROUND_ROBIN) begin
      for (int k = DEPTH-1; k >= 0; k--)
        if (rot[k]) rr_off = IDX_W'(k);
      sel_idx = rr_ptr + rr_off;
    end else if (HIGH_PRIORITY) begin
      for (int k = 0; k < DEPTH; k++)
        if (cand[k]) sel_idx = IDX_W'(k);
    end else begin
      for (int k = DEPTH-1; k >= 0; k--)
        if (cand[k]) sel_idx = IDX_W'(k);
    end
  end

  assign alloc_valid = |cand;
  assign alloc_idx   = alloc_valid ? sel_idx : '0;

  // Flush discards any same-cycle grant or release, including the double-free flag.
  assign grant   = alloc_valid & alloc_ready & ~flush;
  assign rel_ok  = free_valid & ~free_bits[free_idx] & ~flush;
  assign rel_dbl = free_valid &  free_bits[free_idx] & ~flush;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    entry_slot u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .set   (rel_ok && (free_idx == IDX_W'(i))),
      .clr   (grant  && (alloc_idx == IDX_W'(i))),
      .free  (free_bits[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free_count   <= DEPTH_CNT;
      rr_ptr       <= '0;
      err_dbl_free <= 1'b0;
    end else begin
      if (flush) begin
        free_count <= DEPTH_CNT;
        rr_ptr     <= '0;
      end else begin
        case ({rel_ok, grant})
          2'b10:   free_count <= free_count + 1'b1;
          2'b01:   free_count <= free_count - 1'b1;
          default: free_count <= free_count;
        endcase
        if (ROUND_ROBIN && grant) rr_ptr <= alloc_idx + IDX_W'(1);
      end
      if (rel_dbl) err_dbl_free <= 1'b1;
    end
  end

  assign full  = (free_count == '0);
  assign empty = (free_count == DEPTH_CNT);
endmodule

// File: tb/tb_entry_allocator.sv
// Directed bench for entry_allocator: three DEPTH=8 instances (fixed-low, fixed-high, round-robin).

module tb_entry_allocator;
  localparam int D = 8;
  localparam int W = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [D-1:0] lo_elig, hi_elig, rr_elig;
  logic lo_rdy, hi_rdy, rr_rdy, lo_fv, hi_fv, rr_fv, lo_fl, hi_fl, rr_fl;
  logic [W-1:0] lo_fi, hi_fi, rr_fi, lo_ai, hi_ai, rr_ai;
  logic lo_av, hi_av, rr_av, lo_full, hi_full, rr_full;
  logic lo_empty, hi_empty, rr_empty, lo_err, hi_err, rr_err;
  logic [W:0] lo_fc, hi_fc, rr_fc;

  entry_allocator #(.DEPTH(D), .HIGH_PRIORITY(1'b0), .ROUND_ROBIN(1'b0)) u_lo (
    .clk(clk), .rst_n(rst_n), .eligible(lo_elig), .alloc_ready(lo_rdy),
    .alloc_valid(lo_av), .alloc_idx(lo_ai), .free_valid(lo_fv), .free_idx(lo_fi),
    .flush(lo_fl), .free_count(lo_fc), .full(lo_full), .empty(lo_empty),
    .err_dbl_free(lo_err));

  entry_allocator #(.DEPTH(D), .HIGH_PRIORITY(1'b1), .ROUND_ROBIN(1'b0)) u_hi (
    .clk(clk), .rst_n(rst_n), .eligible(hi_elig), .alloc_ready(hi_rdy),
    .alloc_valid(hi_av), .alloc_idx(hi_ai), .free_valid(hi_fv), .free_idx(hi_fi),
    .flush(hi_fl), .free_count(hi_fc), .full(hi_full), .empty(hi_empty),
    .err_dbl_free(hi_err));

  entry_allocator #(.DEPTH(D), .HIGH_PRIORITY(1'b0), .ROUND_ROBIN(1'b1)) u_rr (
    .clk(clk), .rst_n(rst_n), .eligible(rr_elig), .alloc_ready(rr_rdy),
    .alloc_valid(rr_av), .alloc_idx(rr_ai), .free_valid(rr_fv), .free_idx(rr_fi),
    .flush(rr_fl), .free_count(rr_fc), .full(rr_full), .empty(rr_empty),
    .err_dbl_free(rr_err));

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Expected values are queued as stimulus is applied, then popped when the DUT output is sampled.
  task automatic expect_val(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp_v;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $error("FAIL %s: observed %0h with no expected value queued", tag, obs);
    end else begin
      exp_v = exp_q.pop_front();
      assert (obs === exp_v) else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    lo_elig = '0; hi_elig = '0; rr_elig = '0;
    lo_rdy = 0; hi_rdy = 0; rr_rdy = 0;
    lo_fv = 0; hi_fv = 0; rr_fv = 0;
    lo_fl = 0; hi_fl = 0; rr_fl = 0;
    lo_fi = '0; hi_fi = '0; rr_fi = '0;
    #12 rst_n = 1'b1;
    #1;
    expect_val(8); check("rst_free_count", 32'(lo_fc));
    expect_val(0); check("rst_full", 32'(lo_full));
    expect_val(1); check("rst_empty", 32'(lo_empty));
    expect_val(0); check("rst_err", 32'(lo_err));
    expect_val(0); check("rst_valid_no_elig", 32'(lo_av));

    // Fixed low priority drains 0..7.
    step();
    lo_elig = 8'hFF; lo_rdy = 1;
    for (int i = 0; i < D; i++) begin
      #1;
      expect_val(1);     check("t1_valid", 32'(lo_av));
      expect_val(i);     check("t1_idx", 32'(lo_ai));
      expect_val(D - i); check("t1_count", 32'(lo_fc));
      step();
    end
    expect_val(0); check("t1_count_end", 32'(lo_fc));
    expect_val(1); check("t1_full", 32'(lo_full));
    expect_val(0); check("t1_valid_end", 32'(lo_av));
    expect_val(0); check("t1_idx_end", 32'(lo_ai));
    step();
    expect_val(0); check("t1_ready_noop", 32'(lo_fc));

    // Fixed high priority with a sparse mask.
    hi_elig = 8'h3C; hi_rdy = 1;
    #1;
    expect_val(5); check("t2_idx_a", 32'(hi_ai));
    step();
    expect_val(4); check("t2_idx_b", 32'(hi_ai));
    step();
    hi_rdy = 0;
    expect_val(6); check("t2_count", 32'(hi_fc));

    // Round-robin: grant 0,1; free 0; then wrap behaviour.
    rr_elig = 8'hFF; rr_rdy = 1;
    #1;
    expect_val(0); check("t3_idx_0", 32'(rr_ai));
    step();
    expect_val(1); check("t3_idx_1", 32'(rr_ai));
    step();
    rr_rdy = 0; rr_fv = 1; rr_fi = 3'd0;
    step();
    rr_fv = 0; rr_elig = 8'h01; rr_rdy = 1;
    #1;
    expect_val(1); check("t3_valid_wrap", 32'(rr_av));
    expect_val(0); check("t3_idx_wrap", 32'(rr_ai));
    step();
    rr_rdy = 0; rr_elig = 8'hFF;
    #1;
    expect_val(2); check("t3_idx_after_rr1", 32'(rr_ai));
    expect_val(6); check("t3_count", 32'(rr_fc));

    // Grant + release in one cycle; released entry not offered same cycle.
    lo_rdy = 0; lo_fl = 1;
    step();
    lo_fl = 0; lo_rdy = 1;
    step(); step(); step();
    lo_fv = 1; lo_fi = 3'd1;
    #1;
    expect_val(5); check("t4_count_before", 32'(lo_fc));
    expect_val(3); check("t4_idx_no_bypass", 32'(lo_ai));
    step();
    lo_fv = 0; lo_rdy = 0;
    #1;
    expect_val(5); check("t4_count_after", 32'(lo_fc));
    expect_val(1); check("t4_idx_released", 32'(lo_ai));

    // Flush with grant and release pending.
    lo_fl = 1; lo_rdy = 1; lo_fv = 1; lo_fi = 3'd0;
    #1;
    expect_val(1); check("t6_valid_during_flush", 32'(lo_av));
    step();
    lo_fl = 0; lo_rdy = 0; lo_fv = 0;
    expect_val(8); check("t6_count", 32'(lo_fc));
    expect_val(1); check("t6_empty", 32'(lo_empty));
    expect_val(0); check("t6_err_untouched", 32'(lo_err));

    // RR flush resets the pointer: all free again, offer restarts at 0.
    rr_fl = 1; rr_rdy = 1;
    step();
    rr_fl = 0; rr_rdy = 0;
    #1;
    expect_val(0); check("t6_rr_ptr_zero", 32'(rr_ai));
    expect_val(8); check("t6_rr_count", 32'(rr_fc));

    // Double free of an already-free entry.
    lo_fv = 1; lo_fi = 3'd6;
    step();
    lo_fv = 0;
    expect_val(8); check("t5_count", 32'(lo_fc));
    expect_val(1); check("t5_err", 32'(lo_err));
    lo_fl = 1;
    step();
    lo_fl = 0;
    expect_val(1); check("t5_err_after_flush", 32'(lo_err));

    // Asynchronous reset mid-run, checked before any clock edge.
    hi_rdy = 1;
    step();
    hi_rdy = 0;
    expect_val(5); check("t6_hi_count_pre", 32'(hi_fc));
    #1 rst_n = 1'b0;
    #1;
    expect_val(8); check("t6_async_count", 32'(hi_fc));
    expect_val(1); check("t6_async_empty", 32'(hi_empty));
    expect_val(0); check("t6_async_err", 32'(lo_err));
    expect_val(5); check("t6_async_hi_offer", 32'(hi_ai));
    rst_n = 1'b1;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not reach its end");
    $fatal(1, "timeout");
  end
endmodule
